// File: rtl/adder_seq_arbiter.sv
// Arbitrates two requesters onto one HALF-bit adder slice; each WIDTH-bit add runs low half then high half.
// Latency: request handshake at cycle N gives resp_valid in cycle N+3. Requests stall until the response is taken.
module adder_seq_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WIDTH-1:0]      req0_a,
  input  logic [WIDTH-1:0]      req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WIDTH-1:0]      req1_a,
  input  logic [WIDTH-1:0]      req1_b,
  output logic [WIDTH/2-1:0]    add_a,
  output logic [WIDTH/2-1:0]    add_b,
  output logic                  add_cin,
  input  logic [WIDTH/2-1:0]    add_sum,
  input  logic                  add_cout,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_carry,
  output logic                  resp_ovf
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [HALF-1:0]   sum_lo_q, sum_lo_d;
  logic              carry_q, carry_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [WIDTH-1:0]  resp_sum_q, resp_sum_d;
  logic              resp_carry_q, resp_carry_d;
  logic              resp_ovf_q, resp_ovf_d;
  logic              gnt0, gnt1;

  // On a tie, the requester that did not win last time gets the slice.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      sum_lo_q     <= '0;
      carry_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
      resp_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      sum_lo_q     <= sum_lo_d;
      carry_q      <= carry_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_carry_q <= resp_carry_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    sum_lo_d     = sum_lo_q;
    carry_d      = carry_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_carry_d = resp_carry_q;
    resp_ovf_d   = resp_ovf_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    add_a        = '0;
    add_b        = '0;
    add_cin      = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 | gnt1) begin
          op_a_d       = gnt1 ? req1_a : req0_a;
          op_b_d       = gnt1 ? req1_b : req0_b;
          id_d         = gnt1;
          last_grant_d = gnt1;
          state_d      = LO;
        end
      end
      LO: begin
        add_a    = op_a_q[HALF-1:0];
        add_b    = op_b_q[HALF-1:0];
        sum_lo_d = add_sum;
        carry_d  = add_cout;
        state_d  = HI;
      end
      HI: begin
        add_a        = op_a_q[WIDTH-1:HALF];
        add_b        = op_b_q[WIDTH-1:HALF];
        add_cin      = carry_q;
        resp_sum_d   = {add_sum, sum_lo_q};
        resp_carry_d = add_cout;
        resp_ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &
                       (add_sum[HALF-1] != op_a_q[WIDTH-1]);
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_carry = resp_carry_q;
  assign resp_ovf   = resp_ovf_q;

endmodule

// File: doc/adder_seq_arbiter.md
Name: adder_seq_arbiter

Overview:
- Shares a single external 16-bit adder slice between two requesters and sequences each WIDTH-bit addition as two half-width passes, low half first, with a carry held in a register between them.
- Sits between client logic (e.g. address or ALU helpers) and the adder16 instance, so that only one slice of adder hardware is needed.
- Returns sum, carry-out, signed-overflow and requester ID through a valid/ready response port.

Parameters:
- WIDTH, 32, full operand width; must be even. The slice width is HALF = WIDTH/2, and the external adder is HALF bits wide.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req1_valid  input  1  requester 1 has an operation pending
- req1_ready  output  1  requester 1 operation accepted this cycle
- req1_a  input  WIDTH  requester 1 operand A
- req1_b  input  WIDTH  requester 1 operand B
- add_a  output  HALF  operand A to the external adder slice
- add_b  output  HALF  operand B to the external adder slice
- add_cin  output  1  carry-in to the external adder slice
- add_sum  input  HALF  combinational sum from the slice
- add_cout  input  1  combinational carry-out from the slice
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts the result
- resp_id  output  1  ID of the requester that owns the result
- resp_sum  output  WIDTH  A+B mod 2^WIDTH
- resp_carry  output  1  unsigned carry-out of bit WIDTH-1
- resp_ovf  output  1  two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0, resp_ovf=0.
  - Operand and carry registers are cleared to 0.
- Reset mid-operation: the operation in flight is discarded and no response is produced. The FSM is back in IDLE on the first clk edge after rst deasserts.
- States: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE:
  - Grant is combinational from valids and last_grant.
    - Only one requester valid: that requester is granted.
    - Both valid: the requester != last_grant is granted.
  - reqN_ready=1 only for the granted requester, and only in IDLE. Both readies are 0 in every other state.
  - On handshake (valid & ready):
    - latch a and b into op_a/op_b;
    - set id to the granted requester and last_grant to id;
    - go to LO.
  - No handshake: stay in IDLE.
- LO:
  - Drive add_a=op_a[HALF-1:0], add_b=op_b[HALF-1:0], add_cin=0.
  - At the edge: sum_lo<=add_sum, carry_r<=add_cout; go to HI.
- HI:
  - Drive add_a=op_a[WIDTH-1:HALF], add_b=op_b[WIDTH-1:HALF], add_cin=carry_r.
  - At the edge:
    - resp_sum <= {add_sum, sum_lo};
    - resp_carry <= add_cout;
    - resp_ovf <= (op_a[MSB]==op_b[MSB]) & (add_sum[HALF-1]!=op_a[MSB]);
    - resp_id <= id; resp_valid <= 1; go to DONE.
- Slice idle: in IDLE and DONE, add_a, add_b and add_cin are driven to 0.
- DONE:
  - resp_* are held stable while resp_valid=1 and resp_ready=0.
  - On resp_ready=1: resp_valid<=0 at the edge and the FSM goes to IDLE.
  - resp_sum, resp_id, resp_carry and resp_ovf keep their last values after the handshake.
- Latency and throughput:
  - Request handshake at cycle N -> resp_valid=1 in cycle N+3.
  - Minimum of 4 cycles per operation; no request is accepted in the same cycle as the response handshake.
- Requester obligations: operands need be stable only in the handshake cycle. A requester may drop valid without a handshake, and the grant re-evaluates every cycle.
- Arithmetic: always modulo 2^WIDTH. Wrap-around sets resp_carry and is not an error.

Test Plan:
- After reset, req0 only, a=0x00010001, b=0x00010001 -> req0_ready=1 in IDLE, resp_valid 3 cycles later with sum=0x00020002, carry=0, ovf=0, id=0.
- req1 only, a=0xFFFF0000, b=0x00010000 -> sum=0x00000000, carry=1, ovf=0, id=1. Check add_cin=0 in both passes.
- a=0xFFFFFFFF, b=0x00000001 -> add_cin=1 during HI, sum=0x00000000, carry=1, ovf=0. Then a=0x7FFFFFFF, b=1 -> sum=0x80000000, carry=0, ovf=1. Then a=0x80000000, b=0x80000000 -> sum=0, carry=1, ovf=1.
- req0 and req1 both held valid continuously (req0 a=0x12345678, b=0x87654321; req1 a=1, b=1):
  - grants alternate 0,1,0,1;
  - results are 0x99999999 (id 0) and 0x00000002 (id 1);
  - readies are never high together.
- resp_ready held low for 5 cycles in DONE -> resp_* stable, both reqN_ready=0, no new operation accepted. Release resp_ready -> IDLE on the next cycle.
- rst asserted asynchronously during HI -> resp_valid=0 immediately, outputs zero, no response emitted. A fresh req0 after deassert completes normally and wins the tie (last_grant reset to 1).
